// File: rtl/instr_bus_code_ram_slave_if.sv
// Instruction bus responder-side signal bundle for the code RAM slave.
// The err signal exists only when INSTR_BUS_CODE_RAM_ERR_EN is defined.
interface instr_bus_code_ram_slave_if;
  logic        req;
  logic [31:0] addr;
  logic        sel;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
`ifdef INSTR_BUS_CODE_RAM_ERR_EN
  logic        err;

  modport master (output req, addr, sel, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, sel, output gnt, rvalid, rdata, err);
`else
  modport master (output req, addr, sel, input gnt, rvalid, rdata);
  modport slave  (input req, addr, sel, output gnt, rvalid, rdata);
`endif
endinterface

// File: rtl/instr_bus_code_ram_slave.sv
// Code RAM responder on the instruction bus: one fetch in flight, programmable wait states.
// Define INSTR_BUS_CODE_RAM_ERR_EN to enable the out-of-window error response.
module instr_bus_code_ram_slave #(
  parameter int MEM_WORDS   = 4096,
  parameter int WINDOW_BITS = 16,
  parameter int WAIT_STATES = 1,
  localparam int AW         = $clog2(MEM_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_bus_code_ram_slave_if.slave  bus,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  input  logic [31:0]                mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t        state;
  logic [2:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          accept;

  assign accept   = bus.req & bus.sel & ((state == IDLE) | (state == RESP));
  assign bus.gnt  = accept;
  assign mem_addr = addr_q;

`ifdef INSTR_BUS_CODE_RAM_ERR_EN
  logic oor_q;

  always_ff @(posedge clk) begin
    if (rst)         oor_q <= 1'b0;
    else if (accept) oor_q <= |(bus.addr[WINDOW_BITS-1:0] >> (AW + 2));
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            addr_q <= bus.addr[AW+1:2];
            cnt    <= WS;
            state  <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end else begin
            state  <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= ACCESS;
        end
        ACCESS:  state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    bus.rvalid = (state == RESP);
    bus.rdata  = '0;
    mem_req    = (state == ACCESS);
`ifdef INSTR_BUS_CODE_RAM_ERR_EN
    bus.err    = 1'b0;
    if (oor_q) mem_req = 1'b0;
    if (state == RESP) begin
      if (oor_q) bus.err   = 1'b1;
      else       bus.rdata = mem_rdata;
    end
`else
    if (state == RESP) bus.rdata = mem_rdata;
`endif
  end

  // Address bits outside the word index are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:AW+2], bus.addr[1:0], 32'(WINDOW_BITS)};

endmodule

// File: tb/tb_instr_bus_code_ram_slave.sv
// Directed bench for instr_bus_code_ram_slave with three wait-state configurations (0, 1, 3).
// Honours INSTR_BUS_CODE_RAM_ERR_EN the same way as the design.
module tb_instr_bus_code_ram_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram [0:4095];

  instr_bus_code_ram_slave_if bus0 ();
  instr_bus_code_ram_slave_if bus1 ();
  instr_bus_code_ram_slave_if bus3 ();

  logic        mem_req0, mem_req1, mem_req3;
  logic [11:0] mem_addr0, mem_addr1, mem_addr3;
  logic [31:0] mem_rdata0, mem_rdata1, mem_rdata3;

  instr_bus_code_ram_slave #(.MEM_WORDS(4096), .WINDOW_BITS(16), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0));
  instr_bus_code_ram_slave #(.MEM_WORDS(4096), .WINDOW_BITS(16), .WAIT_STATES(1)) dut_w1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1));
  instr_bus_code_ram_slave #(.MEM_WORDS(4096), .WINDOW_BITS(16), .WAIT_STATES(3)) dut_w3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .mem_req(mem_req3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3));

  // RAM macro model: data valid the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (mem_req0) mem_rdata0 <= ram[mem_addr0];
    if (mem_req1) mem_rdata1 <= ram[mem_addr1];
    if (mem_req3) mem_rdata3 <= ram[mem_addr3];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    sample();
    n_checks++; if (bus1.gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", bus1.gnt); end
    n_checks++; if (bus1.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus1.rvalid); end
    n_checks++; if (bus1.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus1.rdata); end
    n_checks++; if (mem_req1 !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req1); end
    n_checks++; if (mem_addr1 !== 12'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr1); end
`ifdef INSTR_BUS_CODE_RAM_ERR_EN
    n_checks++; if (bus1.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus1.err); end
`endif
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    logic activity;
    step();
    bus3.req = 1'b1; bus3.sel = 1'b1; bus3.addr = 32'h0000_0010;
    sample();
    n_checks++; if (bus3.gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b want 1", bus3.gnt); end
    step();                       // WAIT cycle, reset asserted here
    bus3.req = 1'b0; bus3.sel = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    n_checks++; if (bus3.rvalid !== 1'b0 || bus3.rdata !== 32'h0 || mem_req3 !== 1'b0 || mem_addr3 !== 12'h0 || bus3.gnt !== 1'b0)
      begin n_fail++; $display("FAIL rmid_outputs: rvalid=%b rdata=%h mem_req=%b mem_addr=%h gnt=%b want all 0",
                               bus3.rvalid, bus3.rdata, mem_req3, mem_addr3, bus3.gnt); end
    activity = 1'b0;
    step();
    sample();
    activity |= mem_req3 | bus3.rvalid;
    step();                       // two cycles after reset: new request from IDLE
    bus3.req = 1'b1; bus3.sel = 1'b1; bus3.addr = 32'h0000_0008;
    sample();
    n_checks++; if (bus3.gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant: got %b want 1", bus3.gnt); end
    activity |= mem_req3 | bus3.rvalid;
    step();
    bus3.req = 1'b0; bus3.sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      activity |= mem_req3 | bus3.rvalid;
      step();
    end
    n_checks++; if (activity !== 1'b0) begin n_fail++; $display("FAIL rmid_dropped: activity=%b want 0", activity); end
    sample();
    n_checks++; if (mem_req3 !== 1'b1 || mem_addr3 !== 12'd2) begin n_fail++; $display("FAIL rmid_mem: mem_req=%b mem_addr=%0d want 1/2", mem_req3, mem_addr3); end
    step();
    sample();
    n_checks++; if (bus3.rvalid !== 1'b1 || bus3.rdata !== 32'hC0DE_0002) begin n_fail++; $display("FAIL rmid_resp: rvalid=%b rdata=%h want 1/c0de0002", bus3.rvalid, bus3.rdata); end
    step();
  endtask

  task automatic test_single_fetch();
    step();
    bus1.req = 1'b1; bus1.sel = 1'b1; bus1.addr = 32'h0000_0104;
    sample();
    n_checks++; if (bus1.gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b want 1", bus1.gnt); end
    step();
    bus1.req = 1'b0; bus1.sel = 1'b0; bus1.addr = 32'hFFFF_FFFF;
    sample();
    n_checks++; if (mem_req1 !== 1'b0 || bus1.rvalid !== 1'b0) begin n_fail++; $display("FAIL single_wait: mem_req=%b rvalid=%b want 0/0", mem_req1, bus1.rvalid); end
    step();
    sample();
    n_checks++; if (mem_req1 !== 1'b1 || mem_addr1 !== 12'd65) begin n_fail++; $display("FAIL single_mem: mem_req=%b mem_addr=%0d want 1/65", mem_req1, mem_addr1); end
    step();
    sample();
    n_checks++; if (bus1.rvalid !== 1'b1 || bus1.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_resp: rvalid=%b rdata=%h want 1/deadbeef", bus1.rvalid, bus1.rdata); end
`ifdef INSTR_BUS_CODE_RAM_ERR_EN
    n_checks++; if (bus1.err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", bus1.err); end
`endif
    step();
    sample();
    n_checks++; if (bus1.rvalid !== 1'b0 || bus1.rdata !== 32'h0 || mem_req1 !== 1'b0) begin n_fail++; $display("FAIL single_after: rvalid=%b rdata=%h mem_req=%b want 0/0/0", bus1.rvalid, bus1.rdata, mem_req1); end
  endtask

  task automatic test_back_to_back();
    step();
    bus0.req = 1'b1; bus0.sel = 1'b1; bus0.addr = 32'h0000_0000;
    sample();
    n_checks++; if (bus0.gnt !== 1'b1 || bus0.rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_first: gnt=%b rvalid=%b want 1/0", bus0.gnt, bus0.rvalid); end
    for (int k = 0; k < 3; k++) begin
      step();                     // ACCESS
      bus0.addr = 32'((k + 1) * 4);
      if (k == 2) begin bus0.req = 1'b0; bus0.sel = 1'b0; end
      sample();
      n_checks++; if (bus0.gnt !== 1'b0 || mem_req0 !== 1'b1 || mem_addr0 !== 12'(k))
        begin n_fail++; $display("FAIL b2b_access%0d: gnt=%b mem_req=%b mem_addr=%0d want 0/1/%0d", k, bus0.gnt, mem_req0, mem_addr0, k); end
      step();                     // RESP, overlapped with the next accept
      sample();
      n_checks++; if (bus0.rvalid !== 1'b1 || bus0.rdata !== (32'hC0DE_0000 + 32'(k)) || bus0.gnt !== (k < 2))
        begin n_fail++; $display("FAIL b2b_resp%0d: rvalid=%b rdata=%h gnt=%b want 1/%h/%b", k, bus0.rvalid, bus0.rdata, bus0.gnt,
                                 32'hC0DE_0000 + 32'(k), (k < 2)); end
    end
    step();
    sample();
    n_checks++; if (bus0.rvalid !== 1'b0 || mem_req0 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: rvalid=%b mem_req=%b want 0/0", bus0.rvalid, mem_req0); end
  endtask

  task automatic test_busy_unselected();
    logic activity;
    activity = 1'b0;
    step();
    bus1.req = 1'b1; bus1.sel = 1'b0; bus1.addr = 32'h0000_0020;
    sample();
    n_checks++; if (bus1.gnt !== 1'b0) begin n_fail++; $display("FAIL unsel_gnt: got %b want 0", bus1.gnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      sample();
      activity |= mem_req1 | bus1.rvalid | bus1.gnt;
    end
    n_checks++; if (activity !== 1'b0) begin n_fail++; $display("FAIL unsel_quiet: activity=%b want 0", activity); end
    step();
    bus1.sel = 1'b1; bus1.addr = 32'h0000_000C;
    sample();
    n_checks++; if (bus1.gnt !== 1'b1) begin n_fail++; $display("FAIL busy_gnt: got %b want 1", bus1.gnt); end
    step();                       // WAIT, req held, address moves on
    bus1.addr = 32'h0000_0014;
    sample();
    n_checks++; if (bus1.gnt !== 1'b0) begin n_fail++; $display("FAIL busy_wait_gnt: got %b want 0", bus1.gnt); end
    step();                       // ACCESS
    sample();
    n_checks++; if (bus1.gnt !== 1'b0 || mem_req1 !== 1'b1 || mem_addr1 !== 12'd3)
      begin n_fail++; $display("FAIL busy_access: gnt=%b mem_req=%b mem_addr=%0d want 0/1/3", bus1.gnt, mem_req1, mem_addr1); end
    step();                       // RESP with overlapped grant
    sample();
    n_checks++; if (bus1.gnt !== 1'b1 || bus1.rvalid !== 1'b1 || bus1.rdata !== 32'hC0DE_0003)
      begin n_fail++; $display("FAIL busy_resp: gnt=%b rvalid=%b rdata=%h want 1/1/c0de0003", bus1.gnt, bus1.rvalid, bus1.rdata); end
    step();
    bus1.req = 1'b0; bus1.sel = 1'b0;
    step();
    sample();
    n_checks++; if (mem_req1 !== 1'b1 || mem_addr1 !== 12'd5) begin n_fail++; $display("FAIL busy_second_mem: mem_req=%b mem_addr=%0d want 1/5", mem_req1, mem_addr1); end
    step();
    sample();
    n_checks++; if (bus1.rvalid !== 1'b1 || bus1.rdata !== 32'hC0DE_0005) begin n_fail++; $display("FAIL busy_second_resp: rvalid=%b rdata=%h want 1/c0de0005", bus1.rvalid, bus1.rdata); end
  endtask

  task automatic test_out_of_range();
    step();
    bus1.req = 1'b1; bus1.sel = 1'b1; bus1.addr = 32'h0000_4000;
    sample();
    n_checks++; if (bus1.gnt !== 1'b1) begin n_fail++; $display("FAIL oor_gnt: got %b want 1", bus1.gnt); end
    step();
    bus1.req = 1'b0; bus1.sel = 1'b0;
    step();
    sample();
`ifdef INSTR_BUS_CODE_RAM_ERR_EN
    n_checks++; if (mem_req1 !== 1'b0) begin n_fail++; $display("FAIL oor_mem_req: got %b want 0", mem_req1); end
    step();
    sample();
    n_checks++; if (bus1.rvalid !== 1'b1 || bus1.rdata !== 32'h0 || bus1.err !== 1'b1)
      begin n_fail++; $display("FAIL oor_resp: rvalid=%b rdata=%h err=%b want 1/0/1", bus1.rvalid, bus1.rdata, bus1.err); end
`else
    n_checks++; if (mem_req1 !== 1'b1 || mem_addr1 !== 12'd0) begin n_fail++; $display("FAIL oor_wrap_mem: mem_req=%b mem_addr=%0d want 1/0", mem_req1, mem_addr1); end
    step();
    sample();
    n_checks++; if (bus1.rvalid !== 1'b1 || bus1.rdata !== 32'hC0DE_0000)
      begin n_fail++; $display("FAIL oor_wrap_resp: rvalid=%b rdata=%h want 1/c0de0000", bus1.rvalid, bus1.rdata); end
`endif
  endtask

  task automatic test_misaligned();
    step();
    bus1.req = 1'b1; bus1.sel = 1'b1; bus1.addr = 32'h0000_0007;
    sample();
    n_checks++; if (bus1.gnt !== 1'b1) begin n_fail++; $display("FAIL misal_gnt: got %b want 1", bus1.gnt); end
    step();
    bus1.req = 1'b0; bus1.sel = 1'b0;
    step();
    sample();
    n_checks++; if (mem_req1 !== 1'b1 || mem_addr1 !== 12'd1) begin n_fail++; $display("FAIL misal_mem: mem_req=%b mem_addr=%0d want 1/1", mem_req1, mem_addr1); end
    step();
    sample();
    n_checks++; if (bus1.rvalid !== 1'b1 || bus1.rdata !== 32'hC0DE_0001) begin n_fail++; $display("FAIL misal_resp: rvalid=%b rdata=%h want 1/c0de0001", bus1.rvalid, bus1.rdata); end
`ifdef INSTR_BUS_CODE_RAM_ERR_EN
    n_checks++; if (bus1.err !== 1'b0) begin n_fail++; $display("FAIL misal_err: got %b want 0", bus1.err); end
    step();
    sample();
    n_checks++; if (bus1.err !== 1'b0 || bus1.rvalid !== 1'b0) begin n_fail++; $display("FAIL misal_err_idle: err=%b rvalid=%b want 0/0", bus1.err, bus1.rvalid); end
`endif
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'hC0DE_0000 + 32'(i);
    ram[65] = 32'hDEAD_BEEF;
    rst = 1'b1;
    bus0.req = 1'b0; bus0.sel = 1'b0; bus0.addr = '0;
    bus1.req = 1'b0; bus1.sel = 1'b0; bus1.addr = '0;
    bus3.req = 1'b0; bus3.sel = 1'b0; bus3.addr = '0;

    test_reset();
    test_reset_mid_fetch();
    test_single_fetch();
    test_back_to_back();
    test_busy_unselected();
    test_out_of_range();
    test_misaligned();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_bus_code_ram_slave.md
# instr_bus_code_ram_slave

Responder end of the SoC instruction bus: accepts fetch requests routed to the code RAM by the instruction bus address decode, sequences a read of the single-port code RAM macro with a configurable number of wait states, and returns the fetched word with a one-cycle valid strobe. It sits between the instruction bus fabric (core instruction port plus decode) and the code RAM macro. It serves one outstanding fetch at a time. It supports back-to-back acceptance in the response cycle.

## Interface
- MEM_WORDS, 4096: code RAM depth in 32-bit words; power of two; AW = log2(MEM_WORDS).
- WINDOW_BITS, 16: byte-address bits of the code RAM window decoded upstream; WINDOW_BITS ≥ AW+2.
- WAIT_STATES, 1: extra cycles between accept and RAM access; 0..7.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_bus_req  in  1  core fetch request.
- instr_bus_addr  in  32  fetch byte address.
- instr_bus_sel  in  1  decode says this slave is the requested slave.
- instr_bus_gnt  out  1  request accepted this cycle.
- instr_bus_rvalid  out  1  instr_bus_rdata valid this cycle.
- instr_bus_rdata  out  32  fetched instruction word.
- instr_bus_err  out  1  fetch error; present only with INSTR_BUS_CODE_RAM_ERR_EN.
- mem_req  out  1  RAM read strobe.
- mem_addr  out  AW  RAM word address.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_req.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- Acceptance: instr_bus_gnt = instr_bus_req & instr_bus_sel & (state ∈ {IDLE, RESP}). This is combinational. req without sel is ignored.
- On accept:
  - Capture word address addr[AW+1:2] into an internal register. addr[1:0] is ignored.
  - Capture the range flag oor = |addr[WINDOW_BITS-1:AW+2].
  - Load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACCESS.
- ACCESS: mem_req=1 for exactly one cycle, with mem_addr = captured word address. Next state is RESP.
- RESP:
  - instr_bus_rvalid=1 and instr_bus_rdata=mem_rdata.
  - If a new request is accepted in the same cycle, follow the accept rules. Otherwise go to IDLE.
- mem_addr holds the last captured address outside ACCESS.
- instr_bus_rdata is 0 whenever rvalid=0.
- The requester is not required to hold req after gnt. Changes to addr after gnt have no effect on the fetch in flight.

## Timing
- Reset values: state=IDLE, counter=0, captured address=0, gnt=0 (req low or state reset), rvalid=0, rdata=0, err=0, mem_req=0, mem_addr=0.
- Accept at cycle T: mem_req at T+1+WAIT_STATES, rvalid at T+2+WAIT_STATES.
- Throughput: one fetch per WAIT_STATES+2 cycles, with accept overlapping RESP.
- Reset mid-operation (WAIT/ACCESS/RESP): the next cycle is IDLE with all outputs at reset values. The in-flight fetch is dropped with no rvalid.
- Request in WAIT or ACCESS: gnt=0. The requester keeps req high until granted.
- Simultaneous rvalid and gnt in RESP is legal. Old data is returned and the new address is captured in the same edge.

## Configuration
- INSTR_BUS_CODE_RAM_ERR_EN defined:
  - The instr_bus_err port exists.
  - For an oor fetch, mem_req stays 0 in ACCESS, and the RESP cycle drives rvalid=1, rdata=0, err=1. Latency is unchanged.
  - err=0 on every in-range response and whenever rvalid=0.
- Not defined:
  - No err port and no range check.
  - Upper window bits are ignored, so the address wraps modulo MEM_WORDS and mem_req is always issued.

## Test plan
- Reset mid-fetch: WAIT_STATES=3, accept, assert rst in the WAIT cycle -> no mem_req, no rvalid; all outputs 0 the cycle after; a new request 2 cycles later is granted from IDLE.
- Single fetch, WAIT_STATES=1:
  - Stimulus: req+sel, addr=0x0000_0104 at T; model RAM word 65 = 0xDEAD_BEEF.
  - Response: gnt at T, mem_req with mem_addr=65 at T+2, rvalid with rdata=0xDEAD_BEEF at T+3.
- Back-to-back, WAIT_STATES=0, req held with addrs 0x0,0x4,0x8 -> gnt every 2nd cycle; rvalid at T+2,T+4,T+6 returning words 0,1,2; gnt coincides with rvalid after the first.
- Busy/unselected: req with sel=0 in IDLE -> gnt=0, no mem_req. Req+sel held during WAIT -> gnt only at RESP.
- Out of range, addr=0x0000_4000 with MEM_WORDS=4096, WAIT_STATES=1:
  - With INSTR_BUS_CODE_RAM_ERR_EN: no mem_req; rvalid at T+3 with rdata=0, err=1.
  - Without: mem_addr=0 and word 0 is returned.
- Misaligned addr=0x0000_0007 -> mem_addr=1, normal response, err=0.
